sym_slicer_4ask: RTL and testbench



---
 rtl/sym_slicer_4ask_pkg.sv | 20 ++
 rtl/sym_slicer_4ask_block_avg.sv | 57 +++++
 rtl/sym_slicer_4ask.sv | 159 +++++++++++++++
 tb/tb_sym_slicer_4ask.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sym_slicer_4ask_pkg.sv
// slicer_pkg: shared definitions for the 4-ASK symbol slicer.
//   - 4-ASK decision codes (SYM_M3..SYM_P3)
//   - slicer FSM state encoding (ACQ/RUN)
//   - 1s17 saturation limits used for the error and magnitude paths
package slicer_pkg;

    localparam logic [1:0] SYM_M3 = 2'b00;  // -3
    localparam logic [1:0] SYM_M1 = 2'b01;  // -1
    localparam logic [1:0] SYM_P1 = 2'b10;  // +1
    localparam logic [1:0] SYM_P3 = 2'b11;  // +3

    typedef enum logic {
        ACQ = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;

endpackage

// File: rtl/sym_slicer_4ask_block_avg.sv
// block_avg: block averager. Sums 2^ACC_LOG2 unsigned samples, then
// publishes sum >> ACC_LOG2 and pulses done for one cycle. The final
// sample of a block is included in that block's result and the
// accumulator restarts from zero.
//   sys_clk   in   clock
//   reset     in   synchronous, active-high
//   in_valid  in   one-cycle qualifier for in_val
//   in_val    in   unsigned sample, WIDTH bits
//   avg       out  last published block mean (INIT until first block)
//   done      out  one-cycle pulse, aligned with the avg update
module block_avg #(
    parameter int              WIDTH    = 18,
    parameter int              ACC_LOG2 = 10,
    parameter logic [WIDTH-1:0] INIT    = '0
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] avg,
    output logic             done
);

    localparam int AW = WIDTH + ACC_LOG2;

    logic [AW-1:0]       acc;
    logic [AW-1:0]       sum;
    logic [ACC_LOG2-1:0] cnt;
    logic                last;
    logic                unused_sum_lsb;

    assign sum  = acc + AW'(in_val);
    assign last = &cnt;
    assign unused_sum_lsb = ^sum[ACC_LOG2-1:0];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            acc  <= '0;
            cnt  <= '0;
            avg  <= INIT;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_valid) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    acc  <= '0;
                    avg  <= sum[AW-1:ACC_LOG2];
                    done <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/sym_slicer_4ask.sv
// sym_slicer_4ask: decimates the matched-filter output (4 samples per
// symbol) at a selectable phase, slices each symbol to a 4-ASK decision
// against an adaptive reference level, and reports the per-block mean
// squared slicer error.
//   sys_clk     in   system clock
//   reset       in   synchronous, active-high
//   sam_clk_en  in   one-cycle sample strobe
//   y_in        in   signed 1s17 filter output
//   phase_sel   in   symbol sampling phase
//   sym_out     out  decision 00=-3 01=-1 10=+1 11=+3
//   sym_valid   out  one-cycle pulse per decision (RUN only)
//   ref_level   out  mean |x| of last block (REF_INIT before first)
//   mer_err     out  mean e^2 of last block, 1s17
//   block_done  out  one-cycle pulse when ref_level/mer_err update
//   locked      out  high in RUN (exposes the FSM state)
// Handshake: sym_valid and block_done are single-cycle qualifiers with no
// back-pressure; sym_out/ref_level/mer_err are only meaningful while (or
// after) their qualifier is high.
module sym_slicer_4ask
    import slicer_pkg::*;
#(
    parameter int                      WIDTH    = 18,
    parameter int                      SPS_LOG2 = 2,
    parameter int                      ACC_LOG2 = 10,
    parameter logic signed [WIDTH-1:0] REF_INIT = 18'sd65536
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sam_clk_en,
    input  logic signed [WIDTH-1:0]    y_in,
    input  logic        [SPS_LOG2-1:0] phase_sel,
    output logic        [1:0]          sym_out,
    output logic                       sym_valid,
    output logic        [WIDTH-1:0]    ref_level,
    output logic        [WIDTH-1:0]    mer_err,
    output logic                       block_done,
    output logic                       locked
);

    localparam int EW = WIDTH + 1;
    localparam logic signed [EW-1:0]    E_MAX = EW'(SAT_MAX);
    localparam logic signed [EW-1:0]    E_MIN = EW'(SAT_MIN);
    localparam logic signed [WIDTH-1:0] X_MIN = WIDTH'(SAT_MIN);
    localparam logic        [WIDTH-1:0] M_MAX = WIDTH'(SAT_MAX);

    state_t state, state_nxt;

    logic [SPS_LOG2-1:0]      ph;
    logic                     strobe;
    logic signed [WIDTH-1:0]  xs;
    logic                     xs_vld;

    // ---- phase counter and symbol-rate capture ----
    assign strobe = sam_clk_en && (ph == phase_sel);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ph     <= '0;
            xs     <= '0;
            xs_vld <= 1'b0;
        end else begin
            if (sam_clk_en) ph <= ph + 1'b1;
            if (strobe)     xs <= y_in;
            xs_vld <= strobe;
        end
    end

    // ---- slicer / error / magnitude (combinational from xs) ----
    logic signed [EW-1:0]      xs_e, r_e, half_e, d, e_wide;
    logic        [1:0]         sym_c;
    logic signed [WIDTH-1:0]   e_sat;
    logic signed [2*WIDTH-1:0] sq;
    logic        [WIDTH-1:0]   sq_t;
    logic        [WIDTH-1:0]   mag;
    logic                      unused_sq;

    assign xs_e   = {xs[WIDTH-1], xs};
    assign r_e    = {1'b0, ref_level};
    assign half_e = r_e >>> 1;

    always_comb begin
        sym_c = SYM_P3;
        d     = r_e + half_e;
        if (xs_e < -r_e) begin
            sym_c = SYM_M3;
            d     = -(r_e + half_e);
        end else if (xs[WIDTH-1]) begin
            sym_c = SYM_M1;
            d     = -half_e;
        end else if (xs_e < r_e) begin
            sym_c = SYM_P1;
            d     = half_e;
        end
    end

    always_comb begin
        e_wide = xs_e - d;
        e_sat  = e_wide[WIDTH-1:0];
        if (e_wide > E_MAX)      e_sat = E_MAX[WIDTH-1:0];
        else if (e_wide < E_MIN) e_sat = E_MIN[WIDTH-1:0];
    end

    // e in 1s17 squared is 2s34; keep the bits that form a 1s17 value.
    assign sq        = e_sat * e_sat;
    assign sq_t      = sq[2*WIDTH-2:WIDTH-1];
    assign unused_sq = ^{sq[2*WIDTH-1], sq[WIDTH-2:0]};

    // |xs|, with the most negative code clamped to the positive limit.
    always_comb begin
        mag = xs;
        if (xs == X_MIN)        mag = M_MAX;
        else if (xs[WIDTH-1])   mag = -xs;
    end

    // ---- decision register ----
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sym_out   <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= xs_vld && (state == RUN);
            if (xs_vld && (state == RUN)) sym_out <= sym_c;
        end
    end

    // ---- block averagers ----
    logic done_mag, done_err;

    block_avg #(
        .WIDTH(WIDTH), .ACC_LOG2(ACC_LOG2), .INIT(REF_INIT)
    ) u_avg_mag (
        .sys_clk(sys_clk), .reset(reset), .in_valid(xs_vld),
        .in_val(mag), .avg(ref_level), .done(done_mag)
    );

    block_avg #(
        .WIDTH(WIDTH), .ACC_LOG2(ACC_LOG2), .INIT('0)
    ) u_avg_err (
        .sys_clk(sys_clk), .reset(reset), .in_valid(xs_vld),
        .in_val(sq_t), .avg(mer_err), .done(done_err)
    );

    // Both averagers count the same symbols, so their done pulses coincide.
    assign block_done = done_mag & done_err;

    // ---- FSM ----
    always_ff @(posedge sys_clk) begin
        if (reset) state <= ACQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ACQ && block_done) state_nxt = RUN;
    end

    assign locked = (state == RUN);

endmodule

// File: tb/tb_sym_slicer_4ask.sv
module tb_sym_slicer_4ask;

    localparam int WIDTH    = 18;
    localparam int ACC_LOG2 = 4;
    localparam int BLK      = 16;

    logic                     sys_clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     sam_clk_en = 1'b0;
    logic signed [WIDTH-1:0]  y_in = '0;
    logic [1:0]               phase_sel = '0;
    logic [1:0]               sym_out;
    logic                     sym_valid;
    logic [WIDTH-1:0]         ref_level;
    logic [WIDTH-1:0]         mer_err;
    logic                     block_done;
    logic                     locked;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [1:0] exp_q[$];

    sym_slicer_4ask #(
        .WIDTH(WIDTH), .SPS_LOG2(2), .ACC_LOG2(ACC_LOG2), .REF_INIT(18'sd65536)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en),
        .y_in(y_in), .phase_sel(phase_sel), .sym_out(sym_out),
        .sym_valid(sym_valid), .ref_level(ref_level), .mer_err(mer_err),
        .block_done(block_done), .locked(locked)
    );

    // ---- clock ----
    always #5 sys_clk = ~sys_clk;

    // ---- checker ----
    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---- scoreboard: every decision is matched against exp_q ----
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (sym_valid) begin
                if (exp_q.size() == 0) check("sym_valid_unexpected", sym_valid, 0);
                else                   check("sym_out", sym_out, exp_q.pop_front());
            end
            if (block_done) done_cnt++;
        end
    end

    // ---- drivers ----
    task automatic do_reset();
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        y_in       = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_ref_level", ref_level, 65536);
        check("rst_mer_err",   mer_err, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_locked",    locked, 0);
        check("rst_block_done", block_done, 0);
        check("rst_sym_out",   sym_out, 0);
        reset = 1'b0;
        exp_q.delete();
        done_cnt = 0;
    endtask

    // One sample period: strobe for one cycle, then three idle cycles.
    task automatic sample(input logic signed [WIDTH-1:0] v);
        @(negedge sys_clk);
        y_in       = v;
        sam_clk_en = 1'b1;
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    // One symbol = 4 samples; the sample at phase_sel carries v_at.
    // The DUT phase counter restarts at 0 after every reset and the bench
    // always sends whole symbols, so sample index k matches ph=k.
    task automatic symbol(input logic signed [WIDTH-1:0] v_at,
                          input logic signed [WIDTH-1:0] v_other);
        for (int k = 0; k < 4; k++)
            sample((k == int'(phase_sel)) ? v_at : v_other);
    endtask

    task automatic send_block(input logic signed [WIDTH-1:0] v, input bit run,
                              input logic [1:0] exp_sym);
        for (int i = 0; i < BLK; i++) begin
            if (run) exp_q.push_back(exp_sym);
            symbol(v, v);
        end
    endtask

    task automatic drain_check(input string tag);
        repeat (4) @(negedge sys_clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic signed [WIDTH-1:0] pat [4];
        logic [1:0]              pat_sym [4];
        pat[0] = 18'sd98304;  pat_sym[0] = 2'b11;
        pat[1] = 18'sd32768;  pat_sym[1] = 2'b10;
        pat[2] = -18'sd32768; pat_sym[2] = 2'b01;
        pat[3] = -18'sd98304; pat_sym[3] = 2'b00;

        // 1: reset values
        phase_sel = 2'd0;
        do_reset();

        // 2: constant 0.5; d=98304, e=-32768, sq_t=8192
        for (int i = 0; i < BLK - 1; i++) symbol(18'sd65536, 18'sd65536);
        check("t2_no_early_done", done_cnt, 0);
        check("t2_not_locked", locked, 0);
        symbol(18'sd65536, 18'sd65536);
        check("t2_done1", done_cnt, 1);
        check("t2_ref", ref_level, 65536);
        check("t2_mer_acq", mer_err, 8192);
        check("t2_locked", locked, 1);
        send_block(18'sd65536, 1'b1, 2'b11);
        check("t2_done2", done_cnt, 2);
        check("t2_mer_run", mer_err, 8192);
        drain_check("t2_sym_drain");

        // 3: four-level pattern, exact decisions, zero error
        do_reset();
        for (int i = 0; i < BLK; i++) symbol(pat[i % 4], pat[i % 4]);
        check("t3_ref", ref_level, 65536);
        check("t3_locked", locked, 1);
        for (int i = 0; i < BLK; i++) begin
            exp_q.push_back(pat_sym[i % 4]);
            symbol(pat[i % 4], pat[i % 4]);
        end
        check("t3_done2", done_cnt, 2);
        check("t3_mer", mer_err, 0);
        drain_check("t3_sym_drain");

        // 4a: energy only at ph=2, sampled at phase 2
        phase_sel = 2'd2;
        do_reset();
        for (int i = 0; i < BLK; i++) symbol(18'sd65536, 18'sd0);
        check("t4a_ref", ref_level, 65536);
        check("t4a_mer", mer_err, 8192);
        check("t4a_locked", locked, 1);

        // 4b: same stream sampled at phase 0 sees only zeros.
        // ACQ with r=65536: xs=0 -> +1, d=32768, e=-32768, sq_t=8192.
        // Then r=0: the top region is xs>=r, so xs=0 decides 11 with d=0, e=0.
        phase_sel = 2'd0;
        do_reset();
        for (int i = 0; i < BLK; i++) symbol(18'sd0, 18'sd65536);
        check("t4b_ref", ref_level, 0);
        check("t4b_mer_acq", mer_err, 8192);
        for (int i = 0; i < BLK; i++) begin
            exp_q.push_back(2'b11);
            symbol(18'sd0, 18'sd65536);
        end
        check("t4b_mer_run", mer_err, 0);
        check("t4b_done2", done_cnt, 2);
        drain_check("t4b_sym_drain");

        // 5: full-scale negative; |x| clamps to 131071.
        // ACQ r=65536: d=-98304, e=-32768, sq_t=8192.
        // RUN r=131071: d=-196606, e=65534, sq_t=65534^2>>17=32766.
        do_reset();
        send_block(-18'sd131072, 1'b0, 2'b00);
        check("t5_ref", ref_level, 131071);
        check("t5_mer_acq", mer_err, 8192);
        send_block(-18'sd131072, 1'b1, 2'b00);
        check("t5_mer_run", mer_err, 32766);
        check("t5_ref_run", ref_level, 131071);
        drain_check("t5_sym_drain");

        // 6: reset during symbol 9 of the second block
        do_reset();
        send_block(18'sd98304, 1'b0, 2'b00);
        check("t6_ref", ref_level, 98304);
        check("t6_locked", locked, 1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(2'b11);
            symbol(18'sd98304, 18'sd98304);
        end
        @(negedge sys_clk);
        y_in       = 18'sd98304;
        sam_clk_en = 1'b1;
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        reset      = 1'b1;
        @(negedge sys_clk);
        check("t6_rst_ref", ref_level, 65536);
        check("t6_rst_mer", mer_err, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_sym_valid", sym_valid, 0);
        check("t6_rst_block_done", block_done, 0);
        check("t6_rst_sym_out", sym_out, 0);
        check("t6_sym_drain", exp_q.size(), 0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < BLK - 1; i++) symbol(18'sd98304, 18'sd98304);
        check("t6_no_early_done", done_cnt, 0);
        check("t6_no_lock_early", locked, 0);
        symbol(18'sd98304, 18'sd98304);
        check("t6_done", done_cnt, 1);
        check("t6_ref_after", ref_level, 98304);
        check("t6_locked_after", locked, 1);
        drain_check("t6_final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
